sbn_loader: RTL and testbench
=============================

SBN_LOADER -- requirements
Module: sbn_loader

Interface
REQ-001 Parameter: fwidth, 8, address width of the instruction and data memories, equal to the sbn operand field width.
REQ-002 Parameter: dwidth, 32, memory word width; fixed at 32 = 4 bytes, for both imem words (4*fwidth) and dmem words.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: in_valid  input  1  upstream byte valid.
REQ-006 Port: in_data  input  8  upstream byte.
REQ-007 Port: in_ready  output  1  loader accepts a byte; a transfer occurs at posedge clk when in_valid and in_ready are both 1.
REQ-008 Port: mem_we  output  1  one-cycle memory write strobe.
REQ-009 Port: mem_sel  output  1  0 = imem, 1 = dmem.
REQ-010 Port: mem_addr  output  fwidth  write address.
REQ-011 Port: mem_wdata  output  dwidth  write data.
REQ-012 Port: run  output  1  sticky release of the sbn machine; high once loading is complete.
REQ-013 Port: err  output  1  sticky protocol error.

Function
REQ-014 The loader SHALL parse frames: command byte, then optional payload; commands are 0x01 = imem load, 0x02 = dmem load, 0x03 = run; every other value is illegal.
REQ-015 Load-frame payload SHALL be: start address byte, count byte N (N = 0 means 256 words), then N words of 4 bytes each, MSB first.
REQ-016 States SHALL be IDLE, ADDR, COUNT, DATA, RUN and ERR.
REQ-017 in_ready SHALL be 1 in IDLE, ADDR, COUNT and DATA, and 0 in RUN and ERR.
REQ-018 Transitions on an accepted byte: IDLE->ADDR on 0x01/0x02, latching mem_sel; IDLE->RUN on 0x03; IDLE->ERR on any other value; ADDR->COUNT, latching the address; COUNT->DATA, latching N.
REQ-019 In DATA, bytes SHALL be shifted into a 32-bit assembly register MSB first; a 2-bit byte counter SHALL mark the 4th byte.
REQ-020 On acceptance of the 4th byte, the next cycle SHALL present mem_we = 1, mem_wdata = the assembled word, mem_addr = the current address and mem_sel = the latched select, for exactly one cycle.
REQ-021 After each word the address SHALL increment modulo 2^fwidth (0xFF wraps to 0x00) and the remaining word count SHALL decrement.
REQ-022 On acceptance of the last byte of the last word, the state SHALL return to IDLE in the same edge. The write strobe for that word still follows in the next cycle, and a new command byte may be accepted in that same cycle.
REQ-023 No bubbles: back-to-back bytes with in_valid held high SHALL be accepted every cycle, giving at most one mem_we every 4 cycles.
REQ-024 Cycles with in_valid = 0 SHALL leave all parse state unchanged.
REQ-025 When mem_we = 0, mem_addr, mem_wdata and mem_sel SHALL hold their last values.
REQ-026 run SHALL go to 1 on the edge that accepts 0x03 and stay at 1 until rst; run and err are never both 1.
REQ-027 err SHALL go to 1 on the edge that accepts an illegal command and stay at 1 until rst.
REQ-028 In ERR, no further mem_we SHALL occur.

Reset
REQ-029 rst asserted at any time, including mid-word or mid-frame, SHALL immediately force: state IDLE, in_ready 1 (after release), mem_we 0, mem_sel 0, mem_addr 0, mem_wdata 0, run 0, err 0, and byte counter, word count and assembly register all 0.
REQ-030 A partially received word SHALL be discarded on reset and never written.
REQ-031 The first byte accepted after rst deasserts SHALL be parsed as a command.

Verification
REQ-032 Bytes 01 10 02 AA BB CC DD 11 22 33 44, then 03 -> writes imem[0x10] = AABBCCDD and imem[0x11] = 11223344 at least 4 cycles apart; run = 1 after 03; in_ready = 0 afterwards.
REQ-033 Bytes 02 FF 02 00 00 00 05 00 00 00 07 -> writes dmem[0xFF] = 00000005 and dmem[0x00] = 00000007 (address wrap); mem_sel = 1.
REQ-034 Bytes 02 00 00 followed by 1024 bytes -> exactly 256 dmem writes covering addresses 0x00..0xFF, then state IDLE.
REQ-035 Byte 07 in IDLE -> err = 1, in_ready = 0, no mem_we; rst -> err = 0; then 03 -> run = 1.
REQ-036 Bytes 01 00 01 12 34, rst pulse, then 01 00 01 AA BB CC DD -> only one write, imem[0x00] = AABBCCDD.
REQ-037 Random in_valid gaps during REQ-032 stimulus -> identical writes and data.

Source files
------------

// File: rtl/sbn_loader.sv
// Byte-stream loader for an sbn machine: parses command frames and writes
// 32-bit words into the instruction or data memory, then releases the machine.
module sbn_loader #(
  parameter int fwidth = 8,
  parameter int dwidth = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [fwidth-1:0] mem_addr,
  output logic [dwidth-1:0] mem_wdata,
  output logic              run,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, RUN, ERR} state_t;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;
  localparam logic [7:0] CMD_RUN  = 8'h03;

  state_t              state, state_d;
  logic                sel_q, sel_d;
  logic [fwidth-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [dwidth-1:0]   asm_q, asm_d;
  logic                we_d, wsel_d;
  logic [fwidth-1:0]   waddr_d;
  logic [dwidth-1:0]   wdata_d;
  logic                accept;

  assign in_ready = (state != RUN) && (state != ERR);
  assign accept   = in_valid && in_ready;
  assign run      = (state == RUN);
  assign err      = (state == ERR);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d = state;
    sel_d   = sel_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wsel_d  = mem_sel;
    waddr_d = mem_addr;
    wdata_d = mem_wdata;
    if (accept) begin
      unique case (state)
        IDLE: begin
          unique case (in_data)
            CMD_IMEM: begin sel_d = 1'b0; state_d = ADDR; end
            CMD_DMEM: begin sel_d = 1'b1; state_d = ADDR; end
            CMD_RUN:  state_d = RUN;
            default:  state_d = ERR;
          endcase
        end
        ADDR: begin
          addr_d  = in_data[fwidth-1:0];
          state_d = COUNT;
        end
        COUNT: begin
          // A count byte of zero means 256 words; decrementing 0 wraps to 255.
          cnt_d   = in_data;
          bcnt_d  = 2'd0;
          state_d = DATA;
        end
        DATA: begin
          asm_d  = {asm_q[dwidth-9:0], in_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = asm_d;
            waddr_d = addr_q;
            wsel_d  = sel_q;
            addr_d  = addr_q + fwidth'(1);
            cnt_d   = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      mem_we    <= we_d;
      mem_sel   <= wsel_d;
      mem_addr  <= waddr_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_sbn_loader.sv
// Self-checking bench for sbn_loader: command table, directed frames and
// random frame streams compared against a frame-level reference model.
module tb_sbn_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, mem_sel, run, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  sbn_loader #(.fwidth(8), .dwidth(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .run(run), .err(err)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  typedef wr_t wr_q_t[$];
  typedef struct {
    logic [7:0] cmd;
    logic       exp_run;
    logic       exp_err;
    logic       exp_ready;
  } vec_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  wr_q_t got;

  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst && mem_we) got.push_back('{mem_sel, mem_addr, mem_wdata, cyc});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk the byte stream frame by frame and list the writes it implies.
  function automatic void model(input byte_q_t b, output wr_q_t exp,
                                output logic run_e, output logic err_e);
    int i = 0;
    int n;
    logic [7:0] a;
    logic [7:0] cmd;
    exp = {};
    run_e = 1'b0;
    err_e = 1'b0;
    while (i < b.size()) begin
      cmd = b[i];
      i++;
      if (cmd == 8'h01 || cmd == 8'h02) begin
        if (i + 2 > b.size()) break;
        a = b[i];
        n = (b[i+1] == 0) ? 256 : int'(b[i+1]);
        i += 2;
        for (int w = 0; w < n; w++) begin
          if (i + 4 > b.size()) begin i = b.size(); break; end
          exp.push_back('{cmd == 8'h02, a, {b[i], b[i+1], b[i+2], b[i+3]}, 0});
          i += 4;
          a = a + 8'd1;
        end
      end else if (cmd == 8'h03) begin
        run_e = 1'b1;
        break;
      end else begin
        err_e = 1'b1;
        break;
      end
    end
  endfunction

  task automatic send(input logic [7:0] b, input int maxgap);
    int   t = 0;
    logic ok;
    repeat ($urandom_range(0, maxgap)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
      t++;
      if (t > 20) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input byte_q_t b, input int maxgap);
    foreach (b[k]) send(b[k], maxgap);
  endtask

  task automatic finish_check(input string name, input byte_q_t b);
    wr_q_t exp;
    logic  run_e, err_e;
    int    m;
    model(b, exp, run_e, err_e);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_nwrites"}, got.size(), exp.size());
    m = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int k = 0; k < m; k++) begin
      check($sformatf("%s_sel%0d", name, k), {31'd0, got[k].sel}, {31'd0, exp[k].sel});
      check($sformatf("%s_addr%0d", name, k), {24'd0, got[k].addr}, {24'd0, exp[k].addr});
      check($sformatf("%s_data%0d", name, k), got[k].data, exp[k].data);
      if (k > 0)
        check($sformatf("%s_gap%0d", name, k), {31'd0, (got[k].cyc - got[k-1].cyc) >= 4}, 32'd1);
    end
    check({name, "_run"}, {31'd0, run}, {31'd0, run_e});
    check({name, "_err"}, {31'd0, err}, {31'd0, err_e});
    check({name, "_ready"}, {31'd0, in_ready}, {31'd0, !(run_e || err_e)});
    if (exp.size() > 0) begin
      check({name, "_we_idle"}, {31'd0, mem_we}, 32'd0);
      check({name, "_hold_addr"}, {24'd0, mem_addr}, {24'd0, exp[exp.size()-1].addr});
      check({name, "_hold_data"}, mem_wdata, exp[exp.size()-1].data);
      check({name, "_hold_sel"}, {31'd0, mem_sel}, {31'd0, exp[exp.size()-1].sel});
    end
  endtask

  task automatic run_stream(input string name, input byte_q_t b, input int maxgap);
    got.delete();
    feed(b, maxgap);
    finish_check(name, b);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    check({name, "_we"}, {31'd0, mem_we}, 32'd0);
    check({name, "_sel"}, {31'd0, mem_sel}, 32'd0);
    check({name, "_addr"}, {24'd0, mem_addr}, 32'd0);
    check({name, "_wdata"}, mem_wdata, 32'd0);
    check({name, "_run"}, {31'd0, run}, 32'd0);
    check({name, "_err"}, {31'd0, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t    tbl[8];
  byte_q_t s;

  initial begin
    tbl[0] = '{8'h00, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h02, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h03, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h04, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h07, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 1'b0, 1'b1, 1'b0};

    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("por");

    // One command byte from a fresh reset.
    foreach (tbl[k]) begin
      do_reset();
      got.delete();
      send(tbl[k].cmd, 0);
      @(negedge clk);
      check($sformatf("cmd%02h_run", tbl[k].cmd), {31'd0, run}, {31'd0, tbl[k].exp_run});
      check($sformatf("cmd%02h_err", tbl[k].cmd), {31'd0, err}, {31'd0, tbl[k].exp_err});
      check($sformatf("cmd%02h_ready", tbl[k].cmd), {31'd0, in_ready}, {31'd0, tbl[k].exp_ready});
      check($sformatf("cmd%02h_nowe", tbl[k].cmd), got.size(), 32'd0);
    end

    // Two imem words then run, back to back and with gaps.
    do_reset();
    s = '{8'h01, 8'h10, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03};
    run_stream("imem2", s, 0);
    check("imem2_w0", got.size() > 0 ? got[0].data : 32'hX, 32'hAABBCCDD);
    do_reset();
    check_reset_state("rst_after_run");
    run_stream("imem2_gaps", s, 3);

    // dmem address wrap.
    do_reset();
    s = '{8'h02, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h07};
    run_stream("wrap", s, 0);
    check("wrap_a1", got.size() > 1 ? {24'd0, got[1].addr} : 32'hX, 32'h0);

    // Count 0 means 256 words; loader returns to IDLE and takes a run command.
    do_reset();
    s = '{8'h02, 8'h00, 8'h00};
    for (int k = 0; k < 1024; k++) s.push_back(8'($urandom));
    s.push_back(8'h03);
    run_stream("full256", s, 0);

    // Illegal command is sticky until reset.
    do_reset();
    run_stream("illegal", '{8'h07}, 0);
    do_reset();
    check_reset_state("rst_after_err");
    run_stream("run_after_err", '{8'h03}, 0);

    // Reset in the middle of a word discards it.
    do_reset();
    got.delete();
    feed('{8'h01, 8'h00, 8'h01, 8'h12, 8'h34}, 0);
    do_reset();
    check_reset_state("rst_midword");
    s = '{8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    feed(s, 0);
    finish_check("midword", s);

    // Random frame streams with random valid gaps.
    for (int it = 0; it < 20; it++) begin
      int nf;
      do_reset();
      s = {};
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        int n = $urandom_range(1, 3);
        s.push_back($urandom_range(0, 1) ? 8'h02 : 8'h01);
        s.push_back(8'($urandom));
        s.push_back(8'(n));
        for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
      end
      case ($urandom_range(0, 2))
        0: ;
        1: s.push_back(8'h03);
        default: s.push_back(8'($urandom_range(4, 255)));
      endcase
      run_stream($sformatf("rand%0d", it), s, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
